// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: groups every signal between the interrupt controller and its
// user (configuration, claim/complete handshake, interrupt lines to the core
// and the machine-timer view).
//   master modport: drives src, config, timer compare, claim and complete;
//                   observes claim result, ext_intr, timer_intr and mtime.
//   slave modport : the controller side (opposite directions).
interface intr_ctrl_if #(
  parameter int N_SRC   = 8,
  parameter int TIMER_W = 64,
  parameter int ID_W    = $clog2(N_SRC + 1)
);
  logic [N_SRC-1:0]   src;
  logic               cfg_we;
  logic [N_SRC-1:0]   cfg_enable;
  logic [N_SRC-1:0]   cfg_edge;
  logic               tcmp_we;
  logic [TIMER_W-1:0] tcmp_data;
  logic               claim_req;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic               complete_we;
  logic [ID_W-1:0]    complete_id;
  logic               ext_intr;
  logic               timer_intr;
  logic [TIMER_W-1:0] mtime;

  modport master (
    output src, cfg_we, cfg_enable, cfg_edge, tcmp_we, tcmp_data,
           claim_req, complete_we, complete_id,
    input  claim_valid, claim_id, ext_intr, timer_intr, mtime
  );

  modport slave (
    input  src, cfg_we, cfg_enable, cfg_edge, tcmp_we, tcmp_data,
           claim_req, complete_we, complete_id,
    output claim_valid, claim_id, ext_intr, timer_intr, mtime
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller feeding the core's ext_intr / timer_intr.
//   - N_SRC external sources, each edge (rising) or level triggered, with a
//     per-source enable; lowest index wins; claim/complete handshake with
//     IDs (0 = none, source i = ID i+1).
//   - Prescaled free-running mtime with an mtimecmp compare register.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : intr_ctrl_if.slave (src, cfg_*, tcmp_*, claim_*, complete_*,
//          ext_intr, timer_intr, mtime)
module intr_ctrl #(
  parameter int N_SRC    = 8,
  parameter int TIMER_W  = 64,
  parameter int PRESCALE = 1,
  parameter int ID_W     = $clog2(N_SRC + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  intr_ctrl_if.slave  bus
);

  // A one-bit counter is kept even for PRESCALE=1 so the width is never zero.
  localparam int              CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [N_SRC-1:0]   r_src_q;
  logic [N_SRC-1:0]   r_enable;
  logic [N_SRC-1:0]   r_edge;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_in_service;
  logic               r_ext_intr;
  logic               r_claim_valid;
  logic [ID_W-1:0]    r_claim_id;
  logic [TIMER_W-1:0] r_mtime;
  logic [TIMER_W-1:0] r_mtimecmp;
  logic [CNT_W-1:0]   r_presc_cnt;
  logic               r_timer_intr;

  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_cpl_mask;
  logic [N_SRC-1:0]   w_in_service_cpl;
  logic [N_SRC-1:0]   w_eligible_claim;
  logic [N_SRC-1:0]   w_claim_onehot;
  logic [N_SRC-1:0]   w_pending_next;
  logic [N_SRC-1:0]   w_in_service_next;
  logic               w_claim_hit;
  logic [ID_W-1:0]    w_claim_id;
  logic               w_tick;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign w_rise[gi] = bus.src[gi] & ~r_src_q[gi];
      // IDs of 0 or above N_SRC match no source and are therefore ignored.
      assign w_cpl_mask[gi] = bus.complete_we && (bus.complete_id == ID_W'(gi + 1));
      // Completion is applied before claim selection in the same cycle.
      assign w_in_service_cpl[gi] = r_in_service[gi] & ~w_cpl_mask[gi];
      assign w_eligible_claim[gi] = r_pending[gi] & r_enable[gi] & ~w_in_service_cpl[gi];
      assign w_claim_onehot[gi]   = bus.claim_req && w_claim_hit &&
                                    (w_claim_id == ID_W'(gi + 1));
      // Edge mode: sticky until claimed; a claim beats a simultaneous rise.
      // Level mode: pending simply follows the line.
      assign w_pending_next[gi] = r_edge[gi] ?
                                  ((r_pending[gi] | w_rise[gi]) & ~w_claim_onehot[gi]) :
                                  bus.src[gi];
      assign w_in_service_next[gi] = w_in_service_cpl[gi] | w_claim_onehot[gi];
    end
  endgenerate

  // Lowest-index priority encoder; scanning downwards leaves the lowest hit.
  always_comb begin
    w_claim_hit = 1'b0;
    w_claim_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible_claim[i]) begin
        w_claim_hit = 1'b1;
        w_claim_id  = ID_W'(i + 1);
      end
    end
  end

  assign w_tick = (r_presc_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_src_q       <= '0;
      r_enable      <= '0;
      r_edge        <= '0;
      r_pending     <= '0;
      r_in_service  <= '0;
      r_ext_intr    <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else begin
      r_src_q      <= bus.src;
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      if (bus.cfg_we) begin
        r_enable <= bus.cfg_enable;
        r_edge   <= bus.cfg_edge;
      end
      // Registered view of the current state: lags pending by one cycle.
      r_ext_intr    <= |(r_pending & r_enable & ~r_in_service);
      r_claim_valid <= bus.claim_req;
      r_claim_id    <= bus.claim_req ? w_claim_id : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mtime      <= '0;
      r_mtimecmp   <= '1;
      r_presc_cnt  <= '0;
      r_timer_intr <= 1'b0;
    end else begin
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
      if (w_tick) begin
        r_mtime <= r_mtime + 1'b1;
      end
      if (bus.tcmp_we) begin
        r_mtimecmp <= bus.tcmp_data;
      end
      r_timer_intr <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.claim_valid = r_claim_valid;
  assign bus.claim_id    = r_claim_id;
  assign bus.ext_intr    = r_ext_intr;
  assign bus.timer_intr  = r_timer_intr;
  assign bus.mtime       = r_mtime;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed stimulus for two intr_ctrl instances
// (u_a: N_SRC=8, TIMER_W=64, PRESCALE=1; u_b: TIMER_W=4, PRESCALE=3) with a
// behavioural model checked every cycle plus literal expectations.
module tb_intr_ctrl;
  localparam int N   = 8;
  localparam int IDW = $clog2(N + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  intr_ctrl_if #(.N_SRC(N), .TIMER_W(64), .ID_W(IDW)) if_a();
  intr_ctrl_if #(.N_SRC(N), .TIMER_W(4),  .ID_W(IDW)) if_b();

  intr_ctrl #(.N_SRC(N), .TIMER_W(64), .PRESCALE(1), .ID_W(IDW)) u_a (
    .clk(clk), .rstn(rstn), .bus(if_a.slave));
  intr_ctrl #(.N_SRC(N), .TIMER_W(4), .PRESCALE(3), .ID_W(IDW)) u_b (
    .clk(clk), .rstn(rstn), .bus(if_b.slave));

  int n_vec = 0;
  int n_err = 0;
  int n_tick = 0;

  // Model state: per-source flags and a cycle count from which both mtime
  // values follow as floor(cycles / PRESCALE) mod 2^TIMER_W.
  bit              m_en[N], m_edge[N], m_pend[N], m_ins[N], m_srcq[N];
  bit              m_ext, m_cv, m_tint_a, m_tint_b;
  int              m_cid, m_cmp_b;
  longint unsigned m_cyc;
  logic [63:0]     m_cmp_a;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_ins[i] = 0; m_srcq[i] = 0;
    end
    m_ext = 0; m_cv = 0; m_cid = 0; m_tint_a = 0; m_tint_b = 0;
    m_cmp_a = '1; m_cmp_b = 15; m_cyc = 0;
  endtask

  task automatic model_step();
    bit ins_tmp[N];
    bit claimed[N];
    bit ext_next;
    bit s;
    int sel, k;
    ext_next = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_ins[i]) ext_next = 1;
    for (int i = 0; i < N; i++) begin
      ins_tmp[i] = m_ins[i];
      claimed[i] = 0;
    end
    k = int'(if_a.complete_id);
    if (if_a.complete_we && k >= 1 && k <= N) ins_tmp[k-1] = 0;
    m_cv  = if_a.claim_req;
    m_cid = 0;
    if (if_a.claim_req) begin
      sel = -1;
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_en[i] && !ins_tmp[i]) sel = i;
      if (sel >= 0) begin
        m_cid = sel + 1;
        ins_tmp[sel] = 1;
        claimed[sel] = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      s = if_a.src[i];
      if (m_edge[i]) m_pend[i] = (m_pend[i] || (s && !m_srcq[i])) && !claimed[i];
      else           m_pend[i] = s;
      m_srcq[i] = s;
      m_ins[i]  = ins_tmp[i];
      if (if_a.cfg_we) begin
        m_en[i]   = if_a.cfg_enable[i];
        m_edge[i] = if_a.cfg_edge[i];
      end
    end
    m_ext    = ext_next;
    m_tint_a = (m_cyc >= m_cmp_a);
    m_tint_b = (((m_cyc / 3) % 16) >= longint'(m_cmp_b));
    m_cyc++;
    if (if_a.tcmp_we) m_cmp_a = if_a.tcmp_data;
    if (if_b.tcmp_we) m_cmp_b = int'(if_b.tcmp_data);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      chk("claim_valid", 64'(if_a.claim_valid), 64'(m_cv));
      chk("claim_id",    64'(if_a.claim_id),    64'(m_cid));
      chk("ext_intr",    64'(if_a.ext_intr),    64'(m_ext));
      chk("timer_intr_a", 64'(if_a.timer_intr), 64'(m_tint_a));
      chk("mtime_a",     if_a.mtime,            m_cyc);
      chk("mtime_b",     64'(if_b.mtime),       (m_cyc / 3) % 16);
      chk("timer_intr_b", 64'(if_b.timer_intr), 64'(m_tint_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    n_tick++;
    #1;
  endtask

  task automatic cfg(logic [N-1:0] en, logic [N-1:0] edg);
    if_a.cfg_we = 1; if_a.cfg_enable = en; if_a.cfg_edge = edg;
    tick();
    if_a.cfg_we = 0;
    $display("cfg: enable=%02h edge=%02h", en, edg);
  endtask

  task automatic do_claim(int exp_id);
    if_a.claim_req = 1;
    tick();
    if_a.claim_req = 0;
    $display("claim: valid=%0b id=%0d (expect %0d)", if_a.claim_valid, if_a.claim_id, exp_id);
    chk("lit_claim_valid", 64'(if_a.claim_valid), 64'd1);
    chk("lit_claim_id",    64'(if_a.claim_id),    64'(exp_id));
  endtask

  task automatic do_complete(int id);
    if_a.complete_we = 1; if_a.complete_id = IDW'(id);
    tick();
    if_a.complete_we = 0; if_a.complete_id = '0;
    $display("complete: id=%0d", id);
  endtask

  task automatic pulse_src(logic [N-1:0] v);
    if_a.src = v;
    tick();
    if_a.src = '0;
  endtask

  task automatic run_until(int n);
    while (n_tick < n) tick();
  endtask

  initial begin
    bit found;
    if_a.src = '0; if_a.cfg_we = 0; if_a.cfg_enable = '0; if_a.cfg_edge = '0;
    if_a.tcmp_we = 0; if_a.tcmp_data = '0; if_a.claim_req = 0;
    if_a.complete_we = 0; if_a.complete_id = '0;
    if_b.src = '0; if_b.cfg_we = 0; if_b.cfg_enable = '0; if_b.cfg_edge = '0;
    if_b.tcmp_we = 0; if_b.tcmp_data = '0; if_b.claim_req = 0;
    if_b.complete_we = 0; if_b.complete_id = '0;
    model_reset();

    // 1: reset values, then free-running mtime
    @(posedge clk); #1;
    chk("lit_rst_claim_valid", 64'(if_a.claim_valid), 64'd0);
    chk("lit_rst_ext_intr",    64'(if_a.ext_intr),    64'd0);
    chk("lit_rst_timer_intr",  64'(if_a.timer_intr),  64'd0);
    chk("lit_rst_mtime",       if_a.mtime,            64'd0);
    @(negedge clk); rstn = 1; n_tick = 0;
    repeat (5) tick();
    chk("lit_mtime_5",      if_a.mtime,            64'd5);
    chk("lit_timer_idle",   64'(if_a.timer_intr),  64'd0);
    $display("timer: mtime=%0d after 5 clocks", if_a.mtime);

    // 2: two edge sources, priority and empty claim
    cfg(8'h0C, 8'hFF);
    pulse_src(8'h0C);
    chk("lit_ext_1cyc", 64'(if_a.ext_intr), 64'd0);
    tick();
    chk("lit_ext_2cyc", 64'(if_a.ext_intr), 64'd1);
    do_claim(3);
    do_claim(4);
    do_claim(0);
    chk("lit_ext_drained", 64'(if_a.ext_intr), 64'd0);
    do_complete(3);
    do_complete(4);

    // 3: level source 1
    cfg(8'h02, 8'h00);
    if_a.src = 8'h02;
    tick(); tick();
    do_claim(2);
    tick();
    chk("lit_ext_in_service", 64'(if_a.ext_intr), 64'd0);
    do_complete(9);
    chk("lit_ext_bad_cpl", 64'(if_a.ext_intr), 64'd0);
    do_complete(2);
    tick();
    chk("lit_ext_level_again", 64'(if_a.ext_intr), 64'd1);
    do_claim(2);
    if_a.src = '0;
    tick(); tick();
    do_complete(2);
    tick(); tick();
    chk("lit_ext_level_low", 64'(if_a.ext_intr), 64'd0);

    // 4: edge source 0 re-firing during service
    cfg(8'h01, 8'h01);
    pulse_src(8'h01);
    tick();
    chk("lit_ext_edge0", 64'(if_a.ext_intr), 64'd1);
    do_claim(1);
    pulse_src(8'h01);
    tick();
    chk("lit_ext_edge_in_svc", 64'(if_a.ext_intr), 64'd0);
    do_claim(0);
    do_complete(1);
    tick();
    chk("lit_ext_after_cpl", 64'(if_a.ext_intr), 64'd1);
    do_claim(1);
    // complete and claim of the same source in one cycle
    pulse_src(8'h01);
    tick();
    if_a.complete_we = 1; if_a.complete_id = IDW'(1);
    do_claim(1);
    if_a.complete_we = 0; if_a.complete_id = '0;

    // asynchronous reset in mid-operation
    #2;
    rstn = 0;
    model_reset();
    #1;
    $display("reset: asserted mid-operation");
    chk("lit_arst_claim_valid", 64'(if_a.claim_valid), 64'd0);
    chk("lit_arst_claim_id",    64'(if_a.claim_id),    64'd0);
    chk("lit_arst_mtime",       if_a.mtime,            64'd0);
    chk("lit_arst_mtime_b",     64'(if_b.mtime),       64'd0);
    @(negedge clk); rstn = 1; n_tick = 0;

    // 5: compare at 10, then raise it to 100
    if_a.tcmp_we = 1; if_a.tcmp_data = 64'd10;
    if_b.tcmp_we = 1; if_b.tcmp_data = 4'd15;
    tick();
    if_a.tcmp_we = 0; if_b.tcmp_we = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (if_a.mtime == 64'd10) found = 1;
    end
    chk("lit_mtime_reach10",   if_a.mtime,           64'd10);
    chk("lit_timer_at10",      64'(if_a.timer_intr), 64'd0);
    tick();
    chk("lit_timer_after10",   64'(if_a.timer_intr), 64'd1);
    $display("timer: timer_intr=%0b at mtime=%0d", if_a.timer_intr, if_a.mtime);
    if_a.tcmp_we = 1; if_a.tcmp_data = 64'd100;
    tick();
    if_a.tcmp_we = 0;
    chk("lit_timer_cmp_lag",   64'(if_a.timer_intr), 64'd1);
    tick();
    chk("lit_timer_cleared",   64'(if_a.timer_intr), 64'd0);

    // 6: 4-bit timer, prescale 3, mtimecmp=15
    run_until(45);
    chk("lit_b_mtime45", 64'(if_b.mtime),      64'd15);
    chk("lit_b_tint45",  64'(if_b.timer_intr), 64'd0);
    run_until(46);
    chk("lit_b_tint46",  64'(if_b.timer_intr), 64'd1);
    run_until(48);
    chk("lit_b_wrap48",  64'(if_b.mtime),      64'd0);
    chk("lit_b_tint48",  64'(if_b.timer_intr), 64'd1);
    run_until(49);
    chk("lit_b_tint49",  64'(if_b.timer_intr), 64'd0);
    run_until(51);
    chk("lit_b_mtime51", 64'(if_b.mtime),      64'd1);
    $display("timer_b: mtime=%0d after %0d clocks", if_b.mtime, n_tick);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
